// File: rtl/axis_pkg.sv
// Shared AXI-Stream routing types: destination-router FSM states and sizing helper.
package axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } route_state_t;

    // Index width that stays legal for a single-entry table.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_dest_route_if.sv
// AXI-Stream bundle for the destination router; the slave side never carries tdest.
interface axis_dest_route_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEST_WIDTH = 3,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tvalid, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tid, tuser, output tready);
endinterface

// File: rtl/axis_dest_match.sv
// Combinational route-table lookup: parallel key compare, lowest enabled index wins.
module axis_dest_match
    import axis_pkg::*;
#(
    parameter int KEY_WIDTH  = 8,
    parameter int DEST_WIDTH = 3,
    parameter int TABLE_SIZE = 4,
    localparam int IDX_W     = idx_width(TABLE_SIZE)
) (
    input  logic [KEY_WIDTH-1:0]             key,
    input  logic [TABLE_SIZE*KEY_WIDTH-1:0]  cfg_key,
    input  logic [TABLE_SIZE*DEST_WIDTH-1:0] cfg_dest,
    input  logic [TABLE_SIZE-1:0]            cfg_en,
    output logic                             hit,
    output logic [IDX_W-1:0]                 index,
    output logic [DEST_WIDTH-1:0]            dest
);
    logic [TABLE_SIZE-1:0] entry_hit;

    generate
        for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_cmp
            assign entry_hit[gi] = cfg_en[gi] && (cfg_key[gi*KEY_WIDTH +: KEY_WIDTH] == key);
        end
    endgenerate

    // Scan high to low so the lowest matching entry is the last one written.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        dest  = '0;
        for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
            if (entry_hit[i]) begin
                hit   = 1'b1;
                index = IDX_W'(i);
                dest  = cfg_dest[i*DEST_WIDTH +: DEST_WIDTH];
            end
        end
    end

endmodule

// File: rtl/axis_dest_route.sv
// AXI-Stream destination router: first-beat key lookup assigns tdest per frame.
// Optional frame statistics are built when AXIS_DEST_ROUTE_STATS_EN is defined.
module axis_dest_route
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEST_WIDTH   = 3,
    parameter int ID_WIDTH     = 8,
    parameter int USER_WIDTH   = 1,
    parameter int KEY_OFFSET   = 0,
    parameter int KEY_WIDTH    = 8,
    parameter int TABLE_SIZE   = 4,
    parameter int MISS_DROP    = 1,
    parameter int DEFAULT_DEST = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    axis_dest_route_if.slave                 s_axis,
    axis_dest_route_if.master                m_axis,
    input  logic [TABLE_SIZE*KEY_WIDTH-1:0]  cfg_key,
    input  logic [TABLE_SIZE*DEST_WIDTH-1:0] cfg_dest,
    input  logic [TABLE_SIZE-1:0]            cfg_en
`ifdef AXIS_DEST_ROUTE_STATS_EN
    ,
    output logic [31:0]                      stat_fwd_frames,
    output logic [31:0]                      stat_drop_frames
`endif
);
    localparam int IDX_W = idx_width(TABLE_SIZE);

    route_state_t          state_reg, state_next;
    logic [DEST_WIDTH-1:0] dest_latched_reg, dest_latched_next;

    logic                  m_valid_reg;
    logic [DATA_WIDTH-1:0] m_data_reg;
    logic                  m_last_reg;
    logic [ID_WIDTH-1:0]   m_id_reg;
    logic [DEST_WIDTH-1:0] m_dest_reg;
    logic [USER_WIDTH-1:0] m_user_reg;

    logic                  s_ready;
    logic                  s_accept;
    logic                  fwd_beat;
    logic [DEST_WIDTH-1:0] beat_dest;

    logic                  match_hit;
    logic [DEST_WIDTH-1:0] match_dest;
    logic [IDX_W-1:0]      unused_match_index;

    axis_dest_match #(
        .KEY_WIDTH  (KEY_WIDTH),
        .DEST_WIDTH (DEST_WIDTH),
        .TABLE_SIZE (TABLE_SIZE)
    ) u_match (
        .key      (s_axis.tdata[KEY_OFFSET +: KEY_WIDTH]),
        .cfg_key  (cfg_key),
        .cfg_dest (cfg_dest),
        .cfg_en   (cfg_en),
        .hit      (match_hit),
        .index    (unused_match_index),
        .dest     (match_dest)
    );

    // Discarded beats never touch the output register, so DROP can always accept.
    assign s_ready  = (state_reg == ST_DROP) || !m_valid_reg || m_axis.tready;
    assign s_accept = s_axis.tvalid && s_ready;
    assign s_axis.tready = s_ready;

    always_comb begin
        state_next        = state_reg;
        dest_latched_next = dest_latched_reg;
        fwd_beat          = 1'b0;
        beat_dest         = dest_latched_reg;
        case (state_reg)
            ST_IDLE: begin
                if (s_accept) begin
                    if (match_hit || (MISS_DROP == 0)) begin
                        fwd_beat          = 1'b1;
                        beat_dest         = match_hit ? match_dest : DEST_WIDTH'(DEFAULT_DEST);
                        dest_latched_next = beat_dest;
                        if (!s_axis.tlast) state_next = ST_FWD;
                    end else if (!s_axis.tlast) begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                if (s_accept) begin
                    fwd_beat = 1'b1;
                    if (s_axis.tlast) state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (s_accept && s_axis.tlast) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            dest_latched_reg <= '0;
            m_valid_reg      <= 1'b0;
            m_data_reg       <= '0;
            m_last_reg       <= 1'b0;
            m_id_reg         <= '0;
            m_dest_reg       <= '0;
            m_user_reg       <= '0;
        end else begin
            state_reg        <= state_next;
            dest_latched_reg <= dest_latched_next;
            if (!m_valid_reg || m_axis.tready) begin
                m_valid_reg <= fwd_beat;
                if (fwd_beat) begin
                    m_data_reg <= s_axis.tdata;
                    m_last_reg <= s_axis.tlast;
                    m_id_reg   <= s_axis.tid;
                    m_dest_reg <= beat_dest;
                    m_user_reg <= s_axis.tuser;
                end
            end
        end
    end

    assign m_axis.tvalid = m_valid_reg;
    assign m_axis.tdata  = m_data_reg;
    assign m_axis.tlast  = m_last_reg;
    assign m_axis.tid    = m_id_reg;
    assign m_axis.tdest  = m_dest_reg;
    assign m_axis.tuser  = m_user_reg;

`ifdef AXIS_DEST_ROUTE_STATS_EN
    // A frame is classified at its accepted tlast by whether that beat was forwarded.
    logic [31:0] fwd_cnt_reg;
    logic [31:0] drop_cnt_reg;
    logic        frame_end;

    assign frame_end = s_accept && s_axis.tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (frame_end && fwd_beat)  fwd_cnt_reg  <= fwd_cnt_reg + 32'd1;
            if (frame_end && !fwd_beat) drop_cnt_reg <= drop_cnt_reg + 32'd1;
        end
    end

    assign stat_fwd_frames  = fwd_cnt_reg;
    assign stat_drop_frames = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_axis_dest_route.sv
// Bench for axis_dest_route: table-driven frames, directed corner cases and random
// traffic against a frame-level scoreboard, on a MISS_DROP=1 and a MISS_DROP=0 instance.
module tb_axis_dest_route;

    localparam int DW = 8, DSW = 3, IW = 8, UW = 1, KW = 8, TS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus shared by both instances; sel picks which one is being checked.
    logic          sel = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic [IW-1:0] s_tid = '0;
    logic [UW-1:0] s_tuser = '0;
    logic          m_tready = 1'b1;
    bit            ready_manual = 1'b1;

    axis_dest_route_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW), .USER_WIDTH(UW)) sa ();
    axis_dest_route_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW), .USER_WIDTH(UW)) ma ();
    axis_dest_route_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW), .USER_WIDTH(UW)) sb ();
    axis_dest_route_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW), .USER_WIDTH(UW)) mb ();

    assign sa.tdata = s_tdata;  assign sb.tdata = s_tdata;
    assign sa.tvalid = s_tvalid; assign sb.tvalid = s_tvalid;
    assign sa.tlast = s_tlast;  assign sb.tlast = s_tlast;
    assign sa.tid = s_tid;      assign sb.tid = s_tid;
    assign sa.tuser = s_tuser;  assign sb.tuser = s_tuser;
    assign sa.tdest = '0;       assign sb.tdest = '0;
    assign ma.tready = m_tready; assign mb.tready = m_tready;

    logic [7:0] key_t [TS];
    logic [2:0] dest_t[TS];
    logic       en_t  [TS];
    logic [TS*KW-1:0]  cfg_key;
    logic [TS*DSW-1:0] cfg_dest;
    logic [TS-1:0]     cfg_en;

    always_comb begin
        cfg_key = '0; cfg_dest = '0; cfg_en = '0;
        for (int i = 0; i < TS; i++) begin
            cfg_key[i*KW +: KW]    = key_t[i];
            cfg_dest[i*DSW +: DSW] = dest_t[i];
            cfg_en[i]              = en_t[i];
        end
    end

`ifdef AXIS_DEST_ROUTE_STATS_EN
    logic [31:0] fwd_a, drop_a, fwd_b, drop_b;
`endif

    axis_dest_route #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW), .USER_WIDTH(UW),
        .KEY_OFFSET(0), .KEY_WIDTH(KW), .TABLE_SIZE(TS), .MISS_DROP(1), .DEFAULT_DEST(0)) dut_a (
        .clk(clk), .rst(rst), .s_axis(sa), .m_axis(ma),
        .cfg_key(cfg_key), .cfg_dest(cfg_dest), .cfg_en(cfg_en)
`ifdef AXIS_DEST_ROUTE_STATS_EN
        , .stat_fwd_frames(fwd_a), .stat_drop_frames(drop_a)
`endif
    );

    axis_dest_route #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW), .USER_WIDTH(UW),
        .KEY_OFFSET(0), .KEY_WIDTH(KW), .TABLE_SIZE(TS), .MISS_DROP(0), .DEFAULT_DEST(7)) dut_b (
        .clk(clk), .rst(rst), .s_axis(sb), .m_axis(mb),
        .cfg_key(cfg_key), .cfg_dest(cfg_dest), .cfg_en(cfg_en)
`ifdef AXIS_DEST_ROUTE_STATS_EN
        , .stat_fwd_frames(fwd_b), .stat_drop_frames(drop_b)
`endif
    );

    wire           sr   = sel ? sb.tready : sa.tready;
    wire           mv   = sel ? mb.tvalid : ma.tvalid;
    wire [DW-1:0]  md   = sel ? mb.tdata  : ma.tdata;
    wire           ml   = sel ? mb.tlast  : ma.tlast;
    wire [IW-1:0]  mi   = sel ? mb.tid    : ma.tid;
    wire [UW-1:0]  mu   = sel ? mb.tuser  : ma.tuser;
    wire [DSW-1:0] mdst = sel ? mb.tdest  : ma.tdest;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct {
        logic [DW-1:0]  data;
        logic           last;
        logic [IW-1:0]  id;
        logic [UW-1:0]  user;
        logic [DSW-1:0] dest;
    } beat_t;

    beat_t      exp_q[$];
    bit         in_frame = 0;
    bit         frame_fwd = 0;
    logic [2:0] frame_dest = '0;
    int         exp_fwd_frames = 0;
    int         exp_drop_frames = 0;
    int         out_count = 0;
    logic [2:0] last_out_dest = '0;

    function automatic void route_lookup(input logic [7:0] key, output bit fwd, output logic [2:0] dest);
        bit found = 0;
        dest = '0;
        for (int i = 0; i < TS; i++) begin
            if (!found && en_t[i] && key_t[i] == key) begin
                found = 1;
                dest  = dest_t[i];
            end
        end
        if (found)         fwd = 1;
        else if (sel == 1) begin fwd = 1; dest = 3'd7; end
        else               fwd = 0;
    endfunction

    task automatic model_reset();
        in_frame = 0; frame_fwd = 0;
        exp_q.delete();
        exp_fwd_frames = 0; exp_drop_frames = 0;
    endtask

    task automatic model_accept(input logic [DW-1:0] data, input bit last,
                                input logic [IW-1:0] id, input logic [UW-1:0] user);
        beat_t b;
        if (!in_frame) begin
            route_lookup(data[7:0], frame_fwd, frame_dest);
            in_frame = 1;
        end
        if (frame_fwd) begin
            b.data = data; b.last = last; b.id = id; b.user = user; b.dest = frame_dest;
            exp_q.push_back(b);
        end
        if (last) begin
            in_frame = 0;
            if (frame_fwd) exp_fwd_frames++;
            else           exp_drop_frames++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic drive_beat(input logic [DW-1:0] data, input bit last,
                              input logic [IW-1:0] id, input logic [UW-1:0] user);
        int  waits = 0;
        bit  mid_drop;
        s_tdata = data; s_tlast = last; s_tid = id; s_tuser = user; s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (sr) break;
            waits++;
            if (waits > 200) begin
                n_tests++; n_fail++;
                $display("FAIL accept_timeout: s_tready stuck at 0, required 1 within 200 cycles");
                s_tvalid = 1'b0;
                return;
            end
        end
        mid_drop = in_frame && !frame_fwd;
        if (mid_drop) check("drop_ready_wait", waits, 0);
        model_accept(data, last, id, user);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] key, input int beats);
        logic [IW-1:0] id = IW'($urandom);
        for (int b = 0; b < beats; b++)
            drive_beat((b == 0) ? DW'(key) : DW'($urandom), b == beats - 1, id, UW'($urandom));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (exp_q.size() != 0 || mv); i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_stats();
`ifdef AXIS_DEST_ROUTE_STATS_EN
        check("stat_fwd_frames",  sel ? fwd_b  : fwd_a,  exp_fwd_frames);
        check("stat_drop_frames", sel ? drop_b : drop_a, exp_drop_frames);
`endif
    endtask

    // ---------------- output monitor ----------------
    logic [21:0] prev_vec = '0;
    bit          prev_stall = 0;
    wire  [21:0] cur_vec = {mv, md, ml, mi, mu, mdst};

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) check("hold_while_stalled", cur_vec, prev_vec);
                if (mv && m_tready) begin
                    $display("[TB] out beat data=%h last=%b id=%h user=%b dest=%0d", md, ml, mi, mu, mdst);
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_beat: got data 0x%0h dest %0d, required no beat", md, mdst);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", {md, ml, mi, mu, mdst}, {e.data, e.last, e.id, e.user, e.dest});
                    end
                    out_count++;
                    last_out_dest = mdst;
                end
                prev_stall = mv && !m_tready;
                prev_vec   = cur_vec;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (!ready_manual) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vectors ----------------
    typedef struct {
        bit         sel;
        logic [7:0] key;
        int         beats;
        bit         exp_fwd;
        logic [2:0] exp_dest;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int start_cnt, c1, c2;
        logic [IW-1:0] id;

        tbl[0] = '{1'b0, 8'h10, 3, 1'b1, 3'd2};
        tbl[1] = '{1'b0, 8'h55, 4, 1'b0, 3'd0};
        tbl[2] = '{1'b0, 8'h20, 2, 1'b1, 3'd5};
        tbl[3] = '{1'b0, 8'h30, 1, 1'b0, 3'd0};
        tbl[4] = '{1'b1, 8'h10, 1, 1'b1, 3'd2};
        tbl[5] = '{1'b1, 8'h55, 2, 1'b1, 3'd7};
        tbl[6] = '{1'b1, 8'h30, 1, 1'b1, 3'd7};

        key_t[0] = 8'h10; dest_t[0] = 3'd2; en_t[0] = 1'b1;
        key_t[1] = 8'h20; dest_t[1] = 3'd5; en_t[1] = 1'b1;
        key_t[2] = 8'h30; dest_t[2] = 3'd4; en_t[2] = 1'b0;
        key_t[3] = 8'h20; dest_t[3] = 3'd6; en_t[3] = 1'b1;

        do_reset();
        @(negedge clk);
        check("reset_a_tvalid", ma.tvalid, 0);
        check("reset_a_tready", sa.tready, 1);
        check("reset_b_tvalid", mb.tvalid, 0);
        check("reset_b_tready", sb.tready, 1);
        check_stats();
        @(posedge clk); #1;

        // Table: first-beat latency/tdest, beat count and final tdest per frame.
        for (int r = 0; r < 7; r++) begin
            if (tbl[r].sel != sel) begin
                check_stats();
                sel = tbl[r].sel;
                do_reset();
            end
            start_cnt = out_count;
            id = IW'($urandom);
            for (int b = 0; b < tbl[r].beats; b++) begin
                drive_beat((b == 0) ? DW'(tbl[r].key) : DW'($urandom), b == tbl[r].beats - 1, id, UW'($urandom));
                if (b == 0) begin
                    check("first_beat_latency", mv, tbl[r].exp_fwd);
                    if (tbl[r].exp_fwd) check("first_beat_tdest", mdst, tbl[r].exp_dest);
                end
            end
            wait_drain();
            check("frame_beats", out_count - start_cnt, tbl[r].exp_fwd ? tbl[r].beats : 0);
            if (tbl[r].exp_fwd) check("frame_tdest", last_out_dest, tbl[r].exp_dest);
        end

        // Back-to-back single-beat frames: hit then default route, one cycle apart.
        drive_beat(8'h10, 1'b1, 8'h01, 1'b0);
        c1 = cyc;
        check("b2b_first_valid", mv, 1);
        check("b2b_first_tdest", mdst, 2);
        drive_beat(8'h55, 1'b1, 8'h02, 1'b1);
        c2 = cyc;
        check("b2b_cycle_gap", c2 - c1, 1);
        check("b2b_second_valid", mv, 1);
        check("b2b_second_tdest", mdst, 7);
        wait_drain();
        check_stats();

        // Downstream stall for three cycles mid-frame.
        sel = 1'b0;
        do_reset();
        drive_beat(8'h10, 1'b0, 8'h33, 1'b0);
        drive_beat(8'hA1, 1'b0, 8'h33, 1'b1);
        m_tready = 1'b0;
        s_tdata = 8'hA2; s_tlast = 1'b0; s_tid = 8'h33; s_tuser = 1'b0; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_s_tready", sr, 0);
            check("stall_m_tvalid", mv, 1);
            @(posedge clk); #1;
        end
        m_tready = 1'b1;
        drive_beat(8'hA2, 1'b0, 8'h33, 1'b0);
        drive_beat(8'hA3, 1'b0, 8'h33, 1'b1);
        drive_beat(8'hA4, 1'b1, 8'h33, 1'b0);
        wait_drain();

        // Table change mid-frame keeps the latched tdest; next frame sees the change.
        drive_beat(8'h10, 1'b0, 8'h44, 1'b0);
        dest_t[0] = 3'd3;
        drive_beat(8'hB1, 1'b0, 8'h44, 1'b0);
        check("cfg_change_inflight", mdst, 2);
        drive_beat(8'hB2, 1'b1, 8'h44, 1'b0);
        drive_beat(8'h10, 1'b1, 8'h45, 1'b0);
        check("cfg_change_next_frame", mdst, 3);
        wait_drain();
        dest_t[0] = 3'd2;
        check_stats();

        // Reset after beat 2 of a 4-beat frame.
        drive_beat(8'h10, 1'b0, 8'h55, 1'b0);
        drive_beat(8'hC1, 1'b0, 8'h55, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_midframe_tvalid", mv, 0);
        @(posedge clk); #1;
        drive_beat(8'h10, 1'b1, 8'h56, 1'b1);
        check("rst_new_frame_valid", mv, 1);
        check("rst_new_frame_tdest", mdst, 2);
        wait_drain();
        check_stats();

        // Random traffic with random backpressure and table edits between frames.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            ready_manual = 1'b0;
            for (int f = 0; f < 40; f++) begin
                int pick = $urandom_range(0, 4);
                logic [7:0] key;
                case (pick)
                    0: key = 8'h10;
                    1: key = 8'h20;
                    2: key = 8'h30;
                    3: key = 8'h55;
                    default: key = 8'($urandom);
                endcase
                if ($urandom_range(0, 7) == 0) begin
                    int e = $urandom_range(0, TS - 1);
                    dest_t[e] = 3'($urandom);
                    en_t[e]   = 1'($urandom);
                end
                send_frame(key, $urandom_range(1, 4));
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    @(posedge clk); #1;
                end
            end
            ready_manual = 1'b1;
            @(posedge clk); #1;
            m_tready = 1'b1;
            wait_drain();
            check_stats();
            dest_t[0] = 3'd2; dest_t[1] = 3'd5; dest_t[2] = 3'd4; dest_t[3] = 3'd6;
            en_t[0] = 1'b1; en_t[1] = 1'b1; en_t[2] = 1'b0; en_t[3] = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
